// File: rtl/vault_sequencer.sv
// Vault unlock sequencer: walks five external phase blocks in order, opens
// the vault when all five complete, and charges a failed attempt (with a
// backoff penalty) whenever a phase fails or times out. Running out of
// attempts latches a terminal alarm that only reset_n can clear.
// Every output is a flop loaded from the next-state decode, so the outputs
// line up with the state they describe and carry no combinational paths.
module vault_sequencer #(
  parameter int PHASE_TIMEOUT  = 32,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] phase_done,
  input  logic [4:0] phase_fail,
  output logic [4:0] phase_start,
  output logic       phase_clear,
  output logic [2:0] active_phase,
  output logic       vault_open,
  output logic       alarm,
  output logic [1:0] attempts_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_PENALTY,
    S_BACKOFF,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  localparam logic [7:0] TIMER_LAST    = 8'(PHASE_TIMEOUT - 1);
  localparam logic [7:0] BACKOFF_LAST  = 8'(BACKOFF_CYCLES - 1);
  localparam logic [1:0] ATTEMPTS_INIT = 2'(MAX_ATTEMPTS);
  localparam logic [2:0] LAST_IDX      = 3'd4;
  localparam logic [2:0] NO_PHASE      = 3'b111;

  state_t     state, state_next;
  logic [2:0] idx, idx_next;
  // Shared between the per-phase watchdog in WAIT and the BACKOFF hold
  // counter; the two uses never overlap and both fit in 8 bits.
  logic [7:0] timer, timer_next;
  logic [1:0] attempts_next;
  logic       abort_taken;

  logic [4:0] phase_start_next;
  logic       phase_clear_next;
  logic [2:0] active_phase_next;
  logic       vault_open_next;
  logic       alarm_next;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      timer         <= '0;
      attempts_left <= ATTEMPTS_INIT;
      phase_start   <= '0;
      phase_clear   <= 1'b0;
      active_phase  <= NO_PHASE;
      vault_open    <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, regardless of statement order.
      state         <= state_next;
      idx           <= idx_next;
      timer         <= timer_next;
      attempts_left <= attempts_next;
      phase_start   <= phase_start_next;
      phase_clear   <= phase_clear_next;
      active_phase  <= active_phase_next;
      vault_open    <= vault_open_next;
      alarm         <= alarm_next;
    end
  end

  // Next-state and datapath decode; abort overrides everything at the end.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no
    // latch can be inferred.
    state_next    = state;
    idx_next      = idx;
    timer_next    = timer;
    attempts_next = attempts_left;
    abort_taken   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          idx_next   = '0;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer + 8'd1;
        // Only the active phase's bits matter; fail beats done beats timeout.
        if (phase_fail[idx]) begin
          state_next = S_PENALTY;
        end else if (phase_done[idx]) begin
          if (idx == LAST_IDX) begin
            state_next    = S_OPEN;
            attempts_next = ATTEMPTS_INIT;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_LAUNCH;
          end
        end else if (timer == TIMER_LAST) begin
          state_next = S_PENALTY;
        end
      end
      S_PENALTY: begin
        attempts_next = attempts_left - 2'd1;
        timer_next    = '0;
        state_next    = (attempts_left == 2'd1) ? S_LOCKOUT : S_BACKOFF;
      end
      S_BACKOFF: begin
        timer_next = timer + 8'd1;
        if (timer == BACKOFF_LAST) begin
          state_next = S_IDLE;
        end
      end
      S_OPEN: begin
        state_next = S_OPEN;
      end
      S_LOCKOUT: begin
        state_next = S_LOCKOUT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort cancels the attempt without charging it; LOCKOUT is deaf to it
    // and IDLE has nothing to cancel.
    if (abort && state != S_IDLE && state != S_LOCKOUT) begin
      state_next    = S_IDLE;
      idx_next      = idx;
      timer_next    = timer;
      attempts_next = attempts_left;
      abort_taken   = 1'b1;
    end
  end

  // Output decode from the upcoming state, registered above.
  always_comb begin
    phase_start_next  = '0;
    phase_clear_next  = 1'b0;
    active_phase_next = NO_PHASE;
    vault_open_next   = 1'b0;
    alarm_next        = 1'b0;

    if (state_next == S_LAUNCH) begin
      phase_start_next = 5'b00001 << idx_next;
    end

    // Clear pulses: first BACKOFF cycle after a penalty, first IDLE cycle
    // after an abort, and held for the whole of LOCKOUT. None of these
    // can coincide with LAUNCH, so phase_start and phase_clear never overlap.
    phase_clear_next = (state_next == S_LOCKOUT) || abort_taken ||
                       (state == S_PENALTY && state_next == S_BACKOFF);

    if (state_next == S_LAUNCH || state_next == S_WAIT ||
        state_next == S_PENALTY) begin
      active_phase_next = idx_next;
    end

    vault_open_next = (state_next == S_OPEN);
    alarm_next      = (state_next == S_LOCKOUT);
  end

endmodule

// File: tb/tb_vault_sequencer.sv
// Directed bench for vault_sequencer with default parameters
// (PHASE_TIMEOUT=32, MAX_ATTEMPTS=3, BACKOFF_CYCLES=8). Inputs change 1 ns
// after a rising edge and outputs are compared there, clear of the edge.
module tb_vault_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] phase_done = '0;
  logic [4:0] phase_fail = '0;
  logic [4:0] phase_start;
  logic       phase_clear;
  logic [2:0] active_phase;
  logic       vault_open;
  logic       alarm;
  logic [1:0] attempts_left;

  int n_compared   = 0;
  int n_mismatched = 0;

  vault_sequencer #(
    .PHASE_TIMEOUT (32),
    .MAX_ATTEMPTS  (3),
    .BACKOFF_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .phase_done   (phase_done),
    .phase_fail   (phase_fail),
    .phase_start  (phase_start),
    .phase_clear  (phase_clear),
    .active_phase (active_phase),
    .vault_open   (vault_open),
    .alarm        (alarm),
    .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; abort = 1'b0; phase_done = '0; phase_fail = '0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Start an attempt and complete phases 0..n-1 on their first WAIT cycle;
  // returns in the LAUNCH cycle of phase index n.
  task automatic run_to_phase(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      phase_done = 5'b00001 << i;
      tick();
      phase_done = '0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if (phase_start !== 5'b0 || phase_clear !== 1'b0 || vault_open !== 1'b0 || alarm !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got ps=%b pc=%b open=%b alarm=%b, want 00000 0 0 0",
               phase_start, phase_clear, vault_open, alarm);
    end
    n_compared++;
    if (active_phase !== 3'b111 || attempts_left !== 2'd3) begin
      n_mismatched++;
      $display("FAIL reset_status: got active=%b attempts=%0d, want 111 3", active_phase, attempts_left);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_compared++;
    if (phase_start !== 5'b0 || active_phase !== 3'b111) begin
      n_mismatched++;
      $display("FAIL reset_idle: got ps=%b active=%b, want 00000 111", phase_start, active_phase);
    end
  endtask

  task automatic test_happy_path();
    logic [4:0] exp_ps;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_ps = 5'b00001 << i;
      n_compared++;
      if (phase_start !== exp_ps || active_phase !== 3'(i)) begin
        n_mismatched++;
        $display("FAIL happy_launch%0d: got ps=%b active=%0d, want %b %0d",
                 i, phase_start, active_phase, exp_ps, i);
      end
      tick();
      tick();
      n_compared++;
      if (phase_start !== 5'b0 || phase_clear !== 1'b0 || active_phase !== 3'(i)) begin
        n_mismatched++;
        $display("FAIL happy_wait%0d: got ps=%b pc=%b active=%0d, want 00000 0 %0d",
                 i, phase_start, phase_clear, active_phase, i);
      end
      tick();
      phase_done = exp_ps;
      tick();
      phase_done = '0;
    end
    n_compared++;
    if (vault_open !== 1'b1 || attempts_left !== 2'd3 || active_phase !== 3'b111 || phase_start !== 5'b0) begin
      n_mismatched++;
      $display("FAIL happy_open: got open=%b attempts=%0d active=%b ps=%b, want 1 3 111 00000",
               vault_open, attempts_left, active_phase, phase_start);
    end
    repeat (3) tick();
    n_compared++;
    if (vault_open !== 1'b1) begin
      n_mismatched++;
      $display("FAIL happy_open_hold: got open=%b, want 1", vault_open);
    end
  endtask

  task automatic test_abort_open();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_compared++;
    if (vault_open !== 1'b0 || phase_clear !== 1'b1 || attempts_left !== 2'd3 || active_phase !== 3'b111) begin
      n_mismatched++;
      $display("FAIL abort_open: got open=%b pc=%b attempts=%0d active=%b, want 0 1 3 111",
               vault_open, phase_clear, attempts_left, active_phase);
    end
    tick();
    n_compared++;
    if (phase_clear !== 1'b0 || vault_open !== 1'b0) begin
      n_mismatched++;
      $display("FAIL abort_open_pulse: got pc=%b open=%b, want 0 0", phase_clear, vault_open);
    end
  endtask

  task automatic test_abort_wait_phase4();
    run_to_phase(3);
    n_compared++;
    if (phase_start !== 5'b01000) begin
      n_mismatched++;
      $display("FAIL abort4_launch: got ps=%b, want 01000", phase_start);
    end
    tick();
    // Abort arrives together with the phase's own done; abort must win.
    abort = 1'b1;
    phase_done = 5'b01000;
    tick();
    abort = 1'b0;
    phase_done = '0;
    n_compared++;
    if (phase_clear !== 1'b1 || phase_start !== 5'b0 || active_phase !== 3'b111 || attempts_left !== 2'd3) begin
      n_mismatched++;
      $display("FAIL abort4_idle: got pc=%b ps=%b active=%b attempts=%0d, want 1 00000 111 3",
               phase_clear, phase_start, active_phase, attempts_left);
    end
    tick();
    n_compared++;
    if (phase_clear !== 1'b0 || phase_start !== 5'b0 || vault_open !== 1'b0) begin
      n_mismatched++;
      $display("FAIL abort4_pulse: got pc=%b ps=%b open=%b, want 0 00000 0",
               phase_clear, phase_start, vault_open);
    end
  endtask

  task automatic test_timeout();
    run_to_phase(1);
    // WAIT with timer 0..31 occupies 32 cycles.
    repeat (32) tick();
    n_compared++;
    if (active_phase !== 3'd1 || phase_clear !== 1'b0 || attempts_left !== 2'd3) begin
      n_mismatched++;
      $display("FAIL timeout_last_wait: got active=%0d pc=%b attempts=%0d, want 1 0 3",
               active_phase, phase_clear, attempts_left);
    end
    tick();
    n_compared++;
    if (active_phase !== 3'd1 || phase_clear !== 1'b0 || phase_start !== 5'b0) begin
      n_mismatched++;
      $display("FAIL timeout_penalty: got active=%0d pc=%b ps=%b, want 1 0 00000",
               active_phase, phase_clear, phase_start);
    end
    tick();
    n_compared++;
    if (attempts_left !== 2'd2 || phase_clear !== 1'b1 || active_phase !== 3'b111) begin
      n_mismatched++;
      $display("FAIL timeout_backoff: got attempts=%0d pc=%b active=%b, want 2 1 111",
               attempts_left, phase_clear, active_phase);
    end
    // start is held high through BACKOFF and must be ignored there.
    start = 1'b1;
    repeat (7) tick();
    n_compared++;
    if (phase_start !== 5'b0 || phase_clear !== 1'b0) begin
      n_mismatched++;
      $display("FAIL timeout_backoff_hold: got ps=%b pc=%b, want 00000 0", phase_start, phase_clear);
    end
    tick();
    n_compared++;
    if (phase_start !== 5'b0 || active_phase !== 3'b111) begin
      n_mismatched++;
      $display("FAIL timeout_idle: got ps=%b active=%b, want 00000 111", phase_start, active_phase);
    end
    tick();
    start = 1'b0;
    n_compared++;
    if (phase_start !== 5'b00001) begin
      n_mismatched++;
      $display("FAIL timeout_restart: got ps=%b, want 00001", phase_start);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_compared++;
    if (attempts_left !== 2'd2 || phase_clear !== 1'b1) begin
      n_mismatched++;
      $display("FAIL timeout_abort: got attempts=%0d pc=%b, want 2 1", attempts_left, phase_clear);
    end
  endtask

  task automatic test_fail_priority();
    do_reset();
    run_to_phase(2);
    tick();
    // Every bit except the active one toggles: nothing may happen.
    phase_done = 5'b11011;
    phase_fail = 5'b11011;
    tick();
    n_compared++;
    if (active_phase !== 3'd2 || phase_start !== 5'b0 || phase_clear !== 1'b0) begin
      n_mismatched++;
      $display("FAIL stray_ignored: got active=%0d ps=%b pc=%b, want 2 00000 0",
               active_phase, phase_start, phase_clear);
    end
    phase_done = 5'b00100;
    phase_fail = 5'b00100;
    tick();
    phase_done = '0;
    phase_fail = '0;
    n_compared++;
    if (active_phase !== 3'd2 || phase_start !== 5'b0 || vault_open !== 1'b0) begin
      n_mismatched++;
      $display("FAIL both_is_fail: got active=%0d ps=%b open=%b, want 2 00000 0",
               active_phase, phase_start, vault_open);
    end
    tick();
    n_compared++;
    if (attempts_left !== 2'd2 || phase_clear !== 1'b1) begin
      n_mismatched++;
      $display("FAIL both_penalty: got attempts=%0d pc=%b, want 2 1", attempts_left, phase_clear);
    end
    repeat (8) tick();
    n_compared++;
    if (active_phase !== 3'b111 || phase_clear !== 1'b0 || phase_start !== 5'b0) begin
      n_mismatched++;
      $display("FAIL both_idle: got active=%b pc=%b ps=%b, want 111 0 00000",
               active_phase, phase_clear, phase_start);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int a = 0; a < 3; a++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      phase_fail = 5'b00001;
      tick();
      phase_fail = '0;
      tick();
      if (a < 2) begin
        n_compared++;
        if (attempts_left !== 2'(2 - a) || alarm !== 1'b0 || phase_clear !== 1'b1) begin
          n_mismatched++;
          $display("FAIL lockout_try%0d: got attempts=%0d alarm=%b pc=%b, want %0d 0 1",
                   a, attempts_left, alarm, phase_clear, 2 - a);
        end
        repeat (8) tick();
      end else begin
        n_compared++;
        if (attempts_left !== 2'd0 || alarm !== 1'b1 || phase_clear !== 1'b1 || vault_open !== 1'b0) begin
          n_mismatched++;
          $display("FAIL lockout_enter: got attempts=%0d alarm=%b pc=%b open=%b, want 0 1 1 0",
                   attempts_left, alarm, phase_clear, vault_open);
        end
      end
    end
    start = 1'b1;
    abort = 1'b1;
    repeat (4) tick();
    n_compared++;
    if (alarm !== 1'b1 || phase_clear !== 1'b1 || phase_start !== 5'b0 || attempts_left !== 2'd0) begin
      n_mismatched++;
      $display("FAIL lockout_terminal: got alarm=%b pc=%b ps=%b attempts=%0d, want 1 1 00000 0",
               alarm, phase_clear, phase_start, attempts_left);
    end
    start = 1'b0;
    abort = 1'b0;
    // Asynchronous reset in the middle of a clock phase.
    #2 reset_n = 1'b0;
    #1;
    n_compared++;
    if (alarm !== 1'b0 || phase_clear !== 1'b0 || attempts_left !== 2'd3 || active_phase !== 3'b111) begin
      n_mismatched++;
      $display("FAIL lockout_reset: got alarm=%b pc=%b attempts=%0d active=%b, want 0 0 3 111",
               alarm, phase_clear, attempts_left, active_phase);
    end
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_compared++;
    if (phase_start !== 5'b00001 || alarm !== 1'b0) begin
      n_mismatched++;
      $display("FAIL lockout_release: got ps=%b alarm=%b, want 00001 0", phase_start, alarm);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_abort_open();
    test_abort_wait_phase4();
    test_timeout();
    test_fail_priority();
    test_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vault_sequencer.md
VAULT_SEQUENCER -- requirements
Module: vault_sequencer

Interface
REQ-001 SHALL have parameter PHASE_TIMEOUT, default 32, max cycles allowed per phase in WAIT (legal 2..255).
REQ-002 SHALL have parameter MAX_ATTEMPTS, default 3, failed attempts before permanent lockout (legal 1..3).
REQ-003 SHALL have parameter BACKOFF_CYCLES, default 8, penalty hold after a non-final failure (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  level; begins an unlock attempt when sampled high in IDLE.
REQ-007 SHALL have port abort  input  1  cancels the current attempt from any state except LOCKOUT.
REQ-008 SHALL have port phase_done  input  5  bit i = phase i+1 completed.
REQ-009 SHALL have port phase_fail  input  5  bit i = phase i+1 failed.
REQ-010 SHALL have port phase_start  output  5  one-hot, one-cycle launch pulse to phase i+1.
REQ-011 SHALL have port phase_clear  output  1  one-cycle pulse resetting all phase blocks.
REQ-012 SHALL have port active_phase  output  3  index 0..4 of the current phase; 3'b111 when none.
REQ-013 SHALL have port vault_open  output  1  high while in OPEN.
REQ-014 SHALL have port alarm  output  1  high while in LOCKOUT.
REQ-015 SHALL have port attempts_left  output  2  MAX_ATTEMPTS minus failed attempts.

Function
REQ-016 SHALL implement states IDLE, LAUNCH, WAIT, PENALTY, BACKOFF, OPEN, LOCKOUT; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, set idx=0 and go to LAUNCH next cycle.
REQ-018 SHALL, in LAUNCH, assert phase_start[idx] for exactly one cycle, clear the 8-bit timer, and go to WAIT.
REQ-019 SHALL, in WAIT, increment timer each cycle and examine only phase_done[idx]/phase_fail[idx]; other bits are ignored.
REQ-020 SHALL, in WAIT, give priority phase_fail[idx] > phase_done[idx] > timeout; fail or timer==PHASE_TIMEOUT-1 goes to PENALTY.
REQ-021 SHALL, on phase_done[idx] with idx<4, increment idx and go to LAUNCH; with idx==4, go to OPEN.
REQ-022 SHALL, in PENALTY (one cycle), decrement attempts_left; if the new value is 0 go to LOCKOUT, else pulse phase_clear and go to BACKOFF.
REQ-023 SHALL hold BACKOFF for exactly BACKOFF_CYCLES cycles, ignoring start, then go to IDLE.
REQ-024 SHALL hold OPEN with vault_open=1 until abort; attempts_left is restored to MAX_ATTEMPTS on entry to OPEN.
REQ-025 SHALL, on abort in LAUNCH/WAIT/PENALTY/BACKOFF/OPEN, pulse phase_clear, go to IDLE, leave attempts_left unchanged; abort has priority over all other events that cycle.
REQ-026 SHALL treat LOCKOUT as terminal: alarm=1, phase_clear held high, start and abort ignored until reset_n.
REQ-027 SHALL drive active_phase=idx in LAUNCH/WAIT/PENALTY, 3'b111 otherwise.
REQ-028 SHALL never assert more than one phase_start bit, and never assert phase_start in the cycle phase_clear is high.

Reset
REQ-029 SHALL, while reset_n=0, force state IDLE, idx=0, timer=0, phase_start=0, phase_clear=0, active_phase=3'b111, vault_open=0, alarm=0, attempts_left=MAX_ATTEMPTS.
REQ-030 SHALL, on reset_n asserted mid-attempt or in LOCKOUT, abandon all state immediately; first edge after release samples IDLE.

Verification
REQ-031 SHALL cover happy path: start, each phase_done[i] 3 cycles after phase_start[i] -> phase_start pulses 00001..10000 in order, vault_open=1, attempts_left=3.
REQ-032 SHALL cover timeout: phase 2 never completes -> PENALTY at timer 31, attempts_left=2, phase_clear pulse, IDLE after 8 BACKOFF cycles.
REQ-033 SHALL cover lockout: three consecutive phase_fail[0] -> attempts_left=0, alarm=1, phase_clear=1, start ignored; reset_n low clears alarm.
REQ-034 SHALL cover simultaneous phase_done[idx] and phase_fail[idx] -> treated as fail; plus stray phase_done on a non-active bit -> ignored.
REQ-035 SHALL cover abort in WAIT of phase 4 and abort in OPEN -> IDLE, one phase_clear pulse, attempts_left unchanged, vault_open=0.
